// File: rtl/mux_nx1_scan.sv
// Registered N:1 channel mux, driven by an external select or by a round-robin scanner that skips masked channels.
// Latency: 1 cycle from din/sel/mask to y/ch/valid/wrap. There is no backpressure: a new decision is made on every edge.
module mux_nx1_scan #(
    parameter int N     = 4,
    parameter int W     = 1,
    parameter int DWELL = 8,
    localparam int SW   = $clog2(N),
    localparam int CW   = $clog2(DWELL + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    input  logic [N-1:0]    mask,
    input  logic [N*W-1:0]  din,
    output logic [W-1:0]    y,
    output logic [SW-1:0]   ch,
    output logic            valid,
    output logic            wrap
);

    typedef enum logic [1:0] {S_IDLE, S_MANUAL, S_SCAN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [W-1:0]  y_nxt;
    logic [SW-1:0] ch_nxt;
    logic          valid_nxt, wrap_nxt;
    logic [SW-1:0] low_idx, next_idx;
    logic          sel_ok;

    function automatic logic [W-1:0] pick(input logic [SW-1:0] k);
        return din[int'(k)*W +: W];
    endfunction

    // Lowest enabled channel, and the next enabled channel strictly above ch (mod N).
    always_comb begin
        int t;
        low_idx  = '0;
        next_idx = ch;
        for (int k = N - 1; k >= 0; k--) begin
            if (mask[k]) low_idx = SW'(k);
        end
        for (int i = N; i >= 1; i--) begin
            t = int'(ch) + i;
            if (t >= N) t = t - N;
            if (mask[SW'(t)]) next_idx = SW'(t);
        end
    end

    always_comb begin
        sel_ok = 1'b0;
        if (int'(sel) < N) sel_ok = mask[sel];
    end

    always_comb begin
        state_nxt = S_IDLE;
        if (en) state_nxt = mode ? S_SCAN : S_MANUAL;
    end

    always_comb begin
        y_nxt     = y;
        ch_nxt    = ch;
        valid_nxt = 1'b0;
        wrap_nxt  = 1'b0;
        cnt_nxt   = '0;
        case (state_nxt)
            S_MANUAL: begin
                if (sel_ok) begin
                    y_nxt     = pick(sel);
                    ch_nxt    = sel;
                    valid_nxt = 1'b1;
                end
            end
            S_SCAN: begin
                // A zero counter marks "no channel owned yet": fresh entry or recovery from an empty mask.
                if (mask == '0) begin
                    cnt_nxt = '0;
                end else if (state != S_SCAN || cnt == '0) begin
                    ch_nxt    = low_idx;
                    y_nxt     = pick(low_idx);
                    valid_nxt = 1'b1;
                    cnt_nxt   = CW'(1);
                end else if (!mask[ch] || cnt == CW'(DWELL)) begin
                    ch_nxt    = next_idx;
                    y_nxt     = pick(next_idx);
                    valid_nxt = 1'b1;
                    wrap_nxt  = (next_idx <= ch);
                    cnt_nxt   = CW'(1);
                end else begin
                    y_nxt     = pick(ch);
                    valid_nxt = 1'b1;
                    cnt_nxt   = cnt + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            y     <= '0;
            ch    <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            y     <= y_nxt;
            ch    <= ch_nxt;
            valid <= valid_nxt;
            wrap  <= wrap_nxt;
        end
    end

endmodule
